// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Buffered UART transmitter. Bytes written by the core are queued in a
//   small circular FIFO and serialized onto tx as 8N1 frames (8E1 when
//   UART_TX_PARITY_EN is defined) at a fixed baud divisor. A queued byte
//   follows the previous stop bit with no idle gap.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     Adds an even-parity bit between the data bits and the stop bit.
//
//   Parameters
//     CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//     FIFO_DEPTH    number of byte entries (power of two, >= 2)
//
//   Ports
//     clk         sole clock, rising edge
//     reset       synchronous, active-high reset
//     send_req    one-cycle write strobe
//     tx_data     byte to enqueue, sampled when send_req = 1
//     tx          serial line, idle high, driven from a flop
//     full        FIFO holds FIFO_DEPTH entries
//     busy        frame in flight or FIFO non-empty
//     overflow    sticky: a send_req was dropped because the FIFO was full
//     fifo_count  current FIFO occupancy
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          send_req,
  input  logic [7:0]                    tx_data,
  output logic                          tx,
  output logic                          full,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PtrW   = $clog2(FIFO_DEPTH);
  localparam int CountW = PtrW + 1;
  localparam int BaudW  = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } txState_t;

  txState_t            state_q, state_d;
  logic [BaudW-1:0]    baudCnt_q, baudCnt_d;
  logic [2:0]          bitIdx_q, bitIdx_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  logic [7:0]          mem [FIFO_DEPTH];
  logic [PtrW-1:0]     wrPtr_q, rdPtr_q;
  logic [CountW-1:0]   count_q;
  logic                overflow_q;

  logic                push;
  logic                pop;
  logic                baudTerm;
  logic                fifoEmpty;

  // full is the registered occupancy, so a push arriving while full is
  // dropped even when a pop frees a slot in the same cycle.
  assign full       = (count_q == CountW'(FIFO_DEPTH));
  assign fifoEmpty  = (count_q == '0);
  assign push       = send_req & ~full;
  assign baudTerm   = (baudCnt_q == BaudW'(CLKS_PER_BIT - 1));

  assign tx         = tx_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != StIdle) | ~fifoEmpty;

  // Transmit sequencing. tx_d is derived from the next state so that the
  // line flop already holds the right level in the first cycle of a bit.
  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    tx_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      StIdle: begin
        baudCnt_d = '0;
        if (!fifoEmpty) begin
          pop      = 1'b1;
          shift_d  = mem[rdPtr_q];
`ifdef UART_TX_PARITY_EN
          parity_d = ^mem[rdPtr_q];
`endif
          state_d  = StStart;
        end
      end

      StStart: begin
        if (baudTerm) begin
          baudCnt_d = '0;
          bitIdx_d  = 3'd0;
          state_d   = StData;
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end

      StData: begin
        if (baudTerm) begin
          baudCnt_d = '0;
          if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
            shift_d  = shift_q >> 1;
          end
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baudTerm) begin
          baudCnt_d = '0;
          state_d   = StStop;
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end
`endif

      StStop: begin
        if (baudTerm) begin
          baudCnt_d = '0;
          // Chain straight into the next start bit when a byte is waiting.
          if (!fifoEmpty) begin
            pop      = 1'b1;
            shift_d  = mem[rdPtr_q];
`ifdef UART_TX_PARITY_EN
            parity_d = ^mem[rdPtr_q];
`endif
            state_d  = StStart;
          end else begin
            state_d  = StIdle;
          end
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // Transmitter state and the glitch-free line flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      baudCnt_q <= '0;
      bitIdx_q  <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // FIFO bookkeeping: pointers wrap naturally, occupancy is a separate
  // counter so full and empty are unambiguous.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (send_req && full) overflow_q <= 1'b1;
    end
  end

  // Storage array carries no reset; stale entries are never read because
  // the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr_q] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo with CLKS_PER_BIT = 4 and FIFO_DEPTH = 4.
// A line monitor reassembles frames from tx and checks them against a
// queue of bytes the stimulus expects to see transmitted.
module tb_uart_tx_fifo;

  localparam int CLKS  = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CLKS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send_req = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx;
  logic       full;
  logic       busy;
  logic       overflow;
  logic [2:0] fifo_count;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;
  int framesDone  = 0;
  int base;
  int lowSamples;

  logic [7:0] expQ[$];
  int         frameStartQ[$];
  logic       frameSmp [FRAME_CYC];

  uart_tx_fifo #(
    .CLKS_PER_BIT (CLKS),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .send_req   (send_req),
    .tx_data    (tx_data),
    .tx         (tx),
    .full       (full),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Free-running cycle count used to timestamp frame starts.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Decode one captured frame and compare it with the scoreboard head.
  task automatic checkFrame();
    logic [7:0] got;
    logic [7:0] exp;
    logic       stable;
    stable = 1'b1;
    for (int b = 0; b < FRAME_BITS; b++)
      for (int k = 1; k < CLKS; k++)
        if (frameSmp[b*CLKS+k] !== frameSmp[b*CLKS]) stable = 1'b0;
    for (int i = 0; i < 8; i++) got[i] = frameSmp[(1+i)*CLKS];
    checkOutput("bit_hold", {31'd0, stable}, 32'd1);
    checkOutput("stop_bit", {31'd0, frameSmp[(FRAME_BITS-1)*CLKS]}, 32'd1);
    checkOutput("frame_expected", {31'd0, (expQ.size() != 0)}, 32'd1);
    if (expQ.size() != 0) begin
      exp = expQ.pop_front();
      checkOutput("frame_data", {24'd0, got}, {24'd0, exp});
`ifdef UART_TX_PARITY_EN
      checkOutput("parity_bit", {31'd0, frameSmp[9*CLKS]}, {31'd0, ^exp});
`endif
    end
    framesDone++;
  endtask

  // Line monitor: samples tx on every falling edge, aborts on reset.
  initial begin
    int  idx;
    bit  inFrame;
    idx = 0;
    inFrame = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        inFrame = 1'b0;
      end else if (!inFrame) begin
        if (tx === 1'b0) begin
          inFrame = 1'b1;
          frameSmp[0] = tx;
          idx = 1;
          frameStartQ.push_back(cyc);
        end
      end else begin
        frameSmp[idx] = tx;
        idx++;
        if (idx == FRAME_CYC) begin
          inFrame = 1'b0;
          checkFrame();
        end
      end
    end
  end

  // Drive a one-cycle send_req; returns 1 ns after the capturing edge.
  task automatic applyStimulus(input logic [7:0] d, input bit accept);
    @(negedge clk);
    send_req = 1'b1;
    tx_data  = d;
    if (accept) expQ.push_back(d);
    @(posedge clk);
    #1;
    send_req = 1'b0;
  endtask

  task automatic waitFrames(input int target, input int maxCyc);
    int n;
    n = 0;
    while (framesDone < target && n < maxCyc) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("frames_done", framesDone, target);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_tx", {31'd0, tx}, 32'd1);
    checkOutput("rst_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_full", {31'd0, full}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    expQ.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Watchdog so the run always reaches its summary line.
  initial begin
    #1000000;
    failCount++;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    // Power-on reset
    doReset();

    // Single byte 0x55: latency, exact frame length, then idle
    applyStimulus(8'h55, 1'b1);
    checkOutput("t1_count_after_push", {29'd0, fifo_count}, 32'd1);
    checkOutput("t1_tx_still_idle", {31'd0, tx}, 32'd1);
    checkOutput("t1_busy_queued", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    checkOutput("t1_start_bit", {31'd0, tx}, 32'd0);
    checkOutput("t1_count_after_pop", {29'd0, fifo_count}, 32'd0);
    repeat (FRAME_CYC - 1) @(posedge clk);
    #1;
    checkOutput("t1_last_stop_busy", {31'd0, busy}, 32'd1);
    checkOutput("t1_last_stop_tx", {31'd0, tx}, 32'd1);
    @(posedge clk); #1;
    checkOutput("t1_idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("t1_frames", framesDone, 32'd1);

    // Back-to-back 0xA3, 0x0F on consecutive cycles: contiguous frames
    frameStartQ.delete();
    base = framesDone;
    applyStimulus(8'hA3, 1'b1);
    checkOutput("t2_count_edge0", {29'd0, fifo_count}, 32'd1);
    applyStimulus(8'h0F, 1'b1);
    checkOutput("t2_count_edge1", {29'd0, fifo_count}, 32'd1);
    repeat (FRAME_CYC - 1) @(posedge clk);
    #1;
    checkOutput("t2_count_before_pop2", {29'd0, fifo_count}, 32'd1);
    @(posedge clk); #1;
    checkOutput("t2_count_after_pop2", {29'd0, fifo_count}, 32'd0);
    checkOutput("t2_second_start", {31'd0, tx}, 32'd0);
    waitFrames(base + 2, 3 * FRAME_CYC);
    checkOutput("t2_starts_seen", frameStartQ.size(), 32'd2);
    if (frameStartQ.size() == 2)
      checkOutput("t2_contiguous", frameStartQ[1] - frameStartQ[0], FRAME_CYC);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t2_idle_busy", {31'd0, busy}, 32'd0);

    // Overflow: first byte in flight, then five more pushes into depth 4
    base = framesDone;
    applyStimulus(8'h11, 1'b1);
    @(posedge clk); #1;
    checkOutput("t3_first_popped", {29'd0, fifo_count}, 32'd0);
    applyStimulus(8'h22, 1'b1);
    applyStimulus(8'h33, 1'b1);
    applyStimulus(8'h44, 1'b1);
    applyStimulus(8'h55, 1'b1);
    checkOutput("t3_full_after_5", {31'd0, full}, 32'd1);
    checkOutput("t3_count_after_5", {29'd0, fifo_count}, 32'd4);
    checkOutput("t3_no_overflow_yet", {31'd0, overflow}, 32'd0);
    applyStimulus(8'h66, 1'b0);
    checkOutput("t3_overflow_set", {31'd0, overflow}, 32'd1);
    checkOutput("t3_count_after_drop", {29'd0, fifo_count}, 32'd4);
    waitFrames(base + 5, 6 * FRAME_CYC);
    repeat (2 * FRAME_CYC) @(posedge clk);
    #1;
    checkOutput("t3_exactly_5_frames", framesDone, base + 5);
    checkOutput("t3_overflow_sticky", {31'd0, overflow}, 32'd1);
    checkOutput("t3_idle_busy", {31'd0, busy}, 32'd0);

    // Mid-frame reset during data bit 3 of 0x3C with 0x81 queued
    doReset();
    applyStimulus(8'h3C, 1'b1);
    applyStimulus(8'h81, 1'b1);
    repeat (17) @(posedge clk);
    #1;
    checkOutput("t4_data_bit3", {31'd0, tx}, 32'd1);
    base = framesDone;
    doReset();
    lowSamples = 0;
    repeat (3 * FRAME_CYC) begin
      @(negedge clk);
      if (tx !== 1'b1) lowSamples++;
    end
    checkOutput("t4_line_stays_idle", lowSamples, 32'd0);
    checkOutput("t4_no_frame", framesDone, base);
    checkOutput("t4_busy_clear", {31'd0, busy}, 32'd0);

    // Pointer wrap: stream 0x00..0x09 keeping occupancy at most 3
    base = framesDone;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'(i), 1'b1);
      checkOutput("t5_count_bound", {31'd0, (fifo_count <= 3'd3)}, 32'd1);
    end
    for (int i = 3; i < 10; i++) begin
      repeat (FRAME_CYC - 1) @(posedge clk);
      applyStimulus(8'(i), 1'b1);
      checkOutput("t5_count_bound", {31'd0, (fifo_count <= 3'd3)}, 32'd1);
    end
    waitFrames(base + 10, 12 * FRAME_CYC);
    checkOutput("t5_queue_drained", expQ.size(), 32'd0);
    checkOutput("t5_no_overflow", {31'd0, overflow}, 32'd0);

    // 0x07: odd number of ones, parity bit is 1 when enabled
    base = framesDone;
    applyStimulus(8'h07, 1'b1);
    @(posedge clk); #1;
    checkOutput("t6_start_bit", {31'd0, tx}, 32'd0);
    repeat (FRAME_CYC - 1) @(posedge clk);
    #1;
    checkOutput("t6_last_stop_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    checkOutput("t6_idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("t6_frames", framesDone, base + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
